// File: rtl/omdc_param_controller.sv
// omdc_param_controller: sequences pixel reads for a sliding-window engine over
// Channels x Rows x Row_Len pixels, emitting Window_Valid at each kernel/stride point.
// Latency: Rd_En is combinational from state/Stop/Finish; Window_Valid follows the producing acceptance by one cycle.
// Backpressure: a pixel moves only when Rd_En && In_Valid; Stop pauses, Finish drains, DRAIN waits on Out_Busy.
// Ports: Start/Stop/Finish control, In_Valid/Out_Busy handshake, Done_Ack, Cfg_* run geometry (0 reads as 1),
//        Rd_En/Window_Valid/Row_Reset/Chan_Reset/Busy/Done status, Col_Idx/Row_Idx/Chan_Idx position.
// Optional: define OMDC_WINDOW_COUNT_EN to add the Window_Count output (windows emitted in the current run).
module omdc_param_controller #(
    parameter int CNT_W = 10,
    parameter int CH_W  = 6
) (
    input  logic             OMDC_STATEMACHINE_Clk,
    input  logic             OMDC_STATEMACHINE_Reset,
    input  logic             Start,
    input  logic             Stop,
    input  logic             Finish,
    input  logic             In_Valid,
    input  logic             Out_Busy,
    input  logic             Done_Ack,
    input  logic [CNT_W-1:0] Cfg_Kernel,
    input  logic [CNT_W-1:0] Cfg_Stride,
    input  logic [CNT_W-1:0] Cfg_Row_Len,
    input  logic [CNT_W-1:0] Cfg_Rows,
    input  logic [CH_W-1:0]  Cfg_Channels,
    output logic             Rd_En,
    output logic             Window_Valid,
    output logic             Row_Reset,
    output logic             Chan_Reset,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] Col_Idx,
    output logic [CNT_W-1:0] Row_Idx,
    output logic [CH_W-1:0]  Chan_Idx
`ifdef OMDC_WINDOW_COUNT_EN
    ,
    output logic [2*CNT_W+CH_W-1:0] Window_Count
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CH_W-1:0]  CH_ONE  = CH_W'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FILL     = 3'd1,
        S_STRIDE   = 3'd2,
        S_NEXT_ROW = 3'd3,
        S_NEXT_CH  = 3'd4,
        S_PAUSED   = 3'd5,
        S_DRAIN    = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    state_t state;
    state_t state_nxt;

    // Latched run geometry; zero config values are promoted to 1 when latched.
    logic [CNT_W-1:0] kernel;
    logic [CNT_W-1:0] stride;
    logic [CNT_W-1:0] row_len;
    logic [CNT_W-1:0] rows;
    logic [CH_W-1:0]  channels;

    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] row;
    logic [CNT_W-1:0] stride_cnt;
    logic [CH_W-1:0]  chan;
    logic             resume_stride;   // state to return to from PAUSED
    logic             win_vld;

    logic run_phase;
    logic rd_en;
    logic accept;
    logic row_end;
    logic last_row;
    logic last_chan;
    logic fill_win;
    logic stride_win;
    logic win_hit;
    logic start_run;
    logic pause_req;

    function automatic logic [CNT_W-1:0] nz_cnt(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_ONE : v;
    endfunction

    function automatic logic [CH_W-1:0] nz_ch(input logic [CH_W-1:0] v);
        return (v == '0) ? CH_ONE : v;
    endfunction

    assign run_phase  = (state == S_FILL) || (state == S_STRIDE);
    assign rd_en      = run_phase && !Stop && !Finish;
    assign accept     = rd_en && In_Valid;
    assign row_end    = (col == row_len - CNT_ONE);
    assign last_row   = (row == rows - CNT_ONE);
    assign last_chan  = (chan == channels - CH_ONE);
    // Col is cleared at row end, so with kernel > row_len fill_win can never fire.
    assign fill_win   = (state == S_FILL) && (col == kernel - CNT_ONE);
    assign stride_win = (state == S_STRIDE) && (stride_cnt == stride - CNT_ONE);
    assign win_hit    = accept && (fill_win || stride_win);
    assign start_run  = (state == S_IDLE) && Start;
    assign pause_req  = run_phase && Stop && !Finish;

    // State register
    always_ff @(posedge OMDC_STATEMACHINE_Clk or negedge OMDC_STATEMACHINE_Reset) begin
        if (!OMDC_STATEMACHINE_Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: Finish beats Stop beats pixel acceptance in FILL/STRIDE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (Start) state_nxt = S_FILL;
            end
            S_FILL, S_STRIDE: begin
                if (Finish) begin
                    state_nxt = S_DRAIN;
                end else if (Stop) begin
                    state_nxt = S_PAUSED;
                end else if (accept) begin
                    if (row_end)       state_nxt = last_row ? S_NEXT_CH : S_NEXT_ROW;
                    else if (fill_win) state_nxt = S_STRIDE;
                end
            end
            S_NEXT_ROW: state_nxt = S_FILL;
            S_NEXT_CH:  state_nxt = last_chan ? S_DRAIN : S_FILL;
            S_PAUSED: begin
                if (Finish)     state_nxt = S_DRAIN;
                else if (Start) state_nxt = resume_stride ? S_STRIDE : S_FILL;
            end
            S_DRAIN: begin
                if (!Out_Busy) state_nxt = S_DONE;
            end
            S_DONE: begin
                if (Done_Ack) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state; only Window_Valid is registered.
    always_comb begin
        Rd_En      = rd_en;
        Row_Reset  = (state == S_NEXT_ROW);
        Chan_Reset = (state == S_NEXT_CH);
        Busy       = (state != S_IDLE) && (state != S_DONE);
        Done       = (state == S_DONE);
    end

    assign Window_Valid = win_vld;
    assign Col_Idx      = col;
    assign Row_Idx      = row;
    assign Chan_Idx     = chan;

    // Counters, config latch and pause memory
    always_ff @(posedge OMDC_STATEMACHINE_Clk or negedge OMDC_STATEMACHINE_Reset) begin
        if (!OMDC_STATEMACHINE_Reset) begin
            kernel        <= '0;
            stride        <= '0;
            row_len       <= '0;
            rows          <= '0;
            channels      <= '0;
            col           <= '0;
            row           <= '0;
            stride_cnt    <= '0;
            chan          <= '0;
            resume_stride <= 1'b0;
            win_vld       <= 1'b0;
        end else begin
            win_vld <= win_hit;
            if (start_run) begin
                kernel        <= nz_cnt(Cfg_Kernel);
                stride        <= nz_cnt(Cfg_Stride);
                row_len       <= nz_cnt(Cfg_Row_Len);
                rows          <= nz_cnt(Cfg_Rows);
                channels      <= nz_ch(Cfg_Channels);
                col           <= '0;
                row           <= '0;
                stride_cnt    <= '0;
                chan          <= '0;
                resume_stride <= 1'b0;
            end else begin
                if (accept) begin
                    col <= row_end ? '0 : col + CNT_ONE;
                    if (fill_win || stride_win)  stride_cnt <= '0;
                    else if (state == S_STRIDE)  stride_cnt <= stride_cnt + CNT_ONE;
                end
                if (pause_req) begin
                    resume_stride <= (state == S_STRIDE);
                end
                if (state == S_NEXT_ROW) begin
                    col <= '0;
                    if (!last_row) row <= row + CNT_ONE;
                end
                if (state == S_NEXT_CH) begin
                    col <= '0;
                    row <= '0;
                    if (!last_chan) chan <= chan + CH_ONE;
                end
            end
        end
    end

`ifdef OMDC_WINDOW_COUNT_EN
    localparam int WC_W = 2*CNT_W + CH_W;
    logic [WC_W-1:0] win_count;

    // Counts alongside Window_Valid; held after the run so DONE can report it.
    always_ff @(posedge OMDC_STATEMACHINE_Clk or negedge OMDC_STATEMACHINE_Reset) begin
        if (!OMDC_STATEMACHINE_Reset) begin
            win_count <= '0;
        end else if (start_run) begin
            win_count <= '0;
        end else if (win_hit) begin
            win_count <= win_count + WC_W'(1);
        end
    end

    assign Window_Count = win_count;
`endif

endmodule

// File: tb/tb_omdc_param_controller.sv
// tb_omdc_param_controller: random and directed stimulus against a pixel-list reference model.
// Latency: n/a (bench).
// Backpressure: In_Valid/Stop/Out_Busy randomized; the model tracks which pixel must move next.
module tb_omdc_param_controller;

    localparam int CNT_W = 10;
    localparam int CH_W  = 6;

    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_PAUSE = 2;
    localparam int P_DRAIN = 3;
    localparam int P_DONE  = 4;

    logic             clk;
    logic             rst_n;
    logic             start, stop, finish, in_valid, out_busy, done_ack;
    logic [CNT_W-1:0] cfg_kernel, cfg_stride, cfg_row_len, cfg_rows;
    logic [CH_W-1:0]  cfg_channels;
    logic             rd_en, window_valid, row_reset, chan_reset, busy, done;
    logic [CNT_W-1:0] col_idx, row_idx;
    logic [CH_W-1:0]  chan_idx;
`ifdef OMDC_WINDOW_COUNT_EN
    logic [2*CNT_W+CH_W-1:0] window_count;
`endif

    omdc_param_controller #(.CNT_W(CNT_W), .CH_W(CH_W)) dut (
        .OMDC_STATEMACHINE_Clk   (clk),
        .OMDC_STATEMACHINE_Reset (rst_n),
        .Start        (start),
        .Stop         (stop),
        .Finish       (finish),
        .In_Valid     (in_valid),
        .Out_Busy     (out_busy),
        .Done_Ack     (done_ack),
        .Cfg_Kernel   (cfg_kernel),
        .Cfg_Stride   (cfg_stride),
        .Cfg_Row_Len  (cfg_row_len),
        .Cfg_Rows     (cfg_rows),
        .Cfg_Channels (cfg_channels),
        .Rd_En        (rd_en),
        .Window_Valid (window_valid),
        .Row_Reset    (row_reset),
        .Chan_Reset   (chan_reset),
        .Busy         (busy),
        .Done         (done),
        .Col_Idx      (col_idx),
        .Row_Idx      (row_idx),
        .Chan_Idx     (chan_idx)
`ifdef OMDC_WINDOW_COUNT_EN
        ,
        .Window_Count (window_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the run is the ordered list of pixels it must accept.
    typedef struct {
        int col;
        int row;
        int ch;
        bit win;
    } pix_t;

    pix_t q[$];
    int   ph;
    bit   exp_wv, exp_rr, exp_cr;
    int   exp_wc;
    int   m_l, m_r;

    int n_chk, n_pass;
    int obs_wv, obs_rr, obs_cr;
    bit last_done, last_busy, last_rd;
    int last_chan;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic build_queue();
        int k, s, l, r, c;
        pix_t p;
        k = (cfg_kernel   == '0) ? 1 : int'(cfg_kernel);
        s = (cfg_stride   == '0) ? 1 : int'(cfg_stride);
        l = (cfg_row_len  == '0) ? 1 : int'(cfg_row_len);
        r = (cfg_rows     == '0) ? 1 : int'(cfg_rows);
        c = (cfg_channels == '0) ? 1 : int'(cfg_channels);
        m_l = l;
        m_r = r;
        q.delete();
        for (int ch = 0; ch < c; ch++)
            for (int rw = 0; rw < r; rw++)
                for (int cl = 0; cl < l; cl++) begin
                    p.col = cl;
                    p.row = rw;
                    p.ch  = ch;
                    p.win = (cl >= k - 1) && (((cl - (k - 1)) % s) == 0);
                    q.push_back(p);
                end
    endtask

    // One clock: called at posedge+1 with inputs driven; samples at negedge, then advances the model.
    task automatic step();
        bit   nwv, nrr, ncr, exp_rd;
        int   nph, nwc;
        pix_t p;
        #4;
        exp_rd = (ph == P_RUN) && !exp_rr && !exp_cr && !stop && !finish;
        chk("rd_en",      64'(rd_en),        64'(exp_rd));
        chk("win_valid",  64'(window_valid), 64'(exp_wv));
        chk("row_reset",  64'(row_reset),    64'(exp_rr));
        chk("chan_reset", 64'(chan_reset),   64'(exp_cr));
        chk("busy",       64'(busy),         64'(ph != P_IDLE && ph != P_DONE));
        chk("done",       64'(done),         64'(ph == P_DONE));
`ifdef OMDC_WINDOW_COUNT_EN
        chk("win_count",  64'(window_count), 64'(exp_wc));
`endif
        if (window_valid) obs_wv++;
        if (row_reset)    obs_rr++;
        if (chan_reset)   obs_cr++;
        last_done = done;
        last_busy = busy;
        last_rd   = rd_en;
        last_chan = int'(chan_idx);

        nwv = 0; nrr = 0; ncr = 0; nph = ph; nwc = exp_wc;
        case (ph)
            P_IDLE: if (start) begin
                build_queue();
                nwc = 0;
                nph = P_RUN;
            end
            P_RUN: begin
                if (exp_rr) begin
                    nph = P_RUN;
                end else if (exp_cr) begin
                    if (q.size() == 0) nph = P_DRAIN;
                end else if (finish) begin
                    nph = P_DRAIN;
                end else if (stop) begin
                    nph = P_PAUSE;
                end else if (in_valid) begin
                    chk("pix_avail", 64'(q.size() > 0), 64'(1));
                    if (q.size() > 0) begin
                        p = q.pop_front();
                        chk("col_idx",  64'(col_idx),  64'(p.col));
                        chk("row_idx",  64'(row_idx),  64'(p.row));
                        chk("chan_idx", 64'(chan_idx), 64'(p.ch));
                        nwv = p.win;
                        if (p.win) nwc = exp_wc + 1;
                        if (p.col == m_l - 1) begin
                            if (p.row < m_r - 1) nrr = 1;
                            else                 ncr = 1;
                        end
                    end
                end
            end
            P_PAUSE: begin
                if (finish)     nph = P_DRAIN;
                else if (start) nph = P_RUN;
            end
            P_DRAIN: if (!out_busy) nph = P_DONE;
            P_DONE:  if (done_ack)  nph = P_IDLE;
            default: nph = P_IDLE;
        endcase
        @(posedge clk);
        #1;
        ph = nph; exp_wv = nwv; exp_rr = nrr; exp_cr = ncr; exp_wc = nwc;
    endtask

    task automatic quiet_inputs();
        start = 0; stop = 0; finish = 0; in_valid = 0; out_busy = 0; done_ack = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        quiet_inputs();
        #4;
        chk("rst_rd_en",  64'(rd_en),        64'(0));
        chk("rst_winv",   64'(window_valid), 64'(0));
        chk("rst_rowrst", 64'(row_reset),    64'(0));
        chk("rst_chrst",  64'(chan_reset),   64'(0));
        chk("rst_busy",   64'(busy),         64'(0));
        chk("rst_done",   64'(done),         64'(0));
        chk("rst_col",    64'(col_idx),      64'(0));
        chk("rst_row",    64'(row_idx),      64'(0));
        chk("rst_chan",   64'(chan_idx),     64'(0));
`ifdef OMDC_WINDOW_COUNT_EN
        chk("rst_wcount", 64'(window_count), 64'(0));
`endif
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1;
        ph = P_IDLE; exp_wv = 0; exp_rr = 0; exp_cr = 0; exp_wc = 0;
        q.delete();
    endtask

    task automatic start_run(input int k, input int s, input int l, input int r, input int c);
        cfg_kernel = CNT_W'(k); cfg_stride = CNT_W'(s); cfg_row_len = CNT_W'(l);
        cfg_rows = CNT_W'(r); cfg_channels = CH_W'(c);
        quiet_inputs();
        in_valid = 1;
        obs_wv = 0; obs_rr = 0; obs_cr = 0;
        start = 1;
        step();
        start = 0;
    endtask

    task automatic run_to_done(input int budget, output int cyc_out, output int chan_out);
        cyc_out  = -1;
        chan_out = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (last_done) begin
                cyc_out  = i;
                chan_out = last_chan;
                break;
            end
        end
        chk("done_reached", 64'(cyc_out > 0), 64'(1));
        done_ack = 1;
        step();
        done_ack = 0;
    endtask

    initial begin
        int dc, dch, drain, seen;
        n_chk = 0; n_pass = 0;
        obs_wv = 0; obs_rr = 0; obs_cr = 0;
        cfg_kernel = '0; cfg_stride = '0; cfg_row_len = '0; cfg_rows = '0; cfg_channels = '0;
        do_reset();

        // Idle after reset: nothing moves without Start.
        in_valid = 1; out_busy = 1;
        repeat (3) step();

        // 3x1 kernel over 5x2, single channel: Done lands 14 cycles after Start.
        start_run(3, 1, 5, 2, 1);
        run_to_done(100, dc, dch);
        chk("r1_done_cycle", 64'(dc),     64'(14));
        chk("r1_windows",    64'(obs_wv), 64'(6));
        chk("r1_row_resets", 64'(obs_rr), 64'(1));
        chk("r1_chan_reset", 64'(obs_cr), 64'(1));

        // Stride 2 over 7 pixels, three channels.
        start_run(3, 2, 7, 1, 3);
        run_to_done(200, dc, dch);
        chk("r2_windows",  64'(obs_wv), 64'(9));
        chk("r2_chan_end", 64'(dch),    64'(2));

        // Kernel wider than the row: rows still end, no windows.
        start_run(6, 1, 4, 2, 1);
        run_to_done(100, dc, dch);
        chk("r3_windows",    64'(obs_wv), 64'(0));
        chk("r3_row_resets", 64'(obs_rr), 64'(1));

        // Pause in STRIDE, resume 5 cycles later; window total unchanged.
        start_run(3, 1, 8, 1, 1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (col_idx == CNT_W'(3)) begin seen = 1; break; end
            step();
        end
        chk("pause_reached", 64'(seen), 64'(1));
        stop = 1; step(); stop = 0;
        chk("pause_rd_drop", 64'(last_rd), 64'(0));
        repeat (5) step();
        start = 1; step(); start = 0;
        run_to_done(100, dc, dch);
        chk("pause_windows", 64'(obs_wv), 64'(6));

        // Finish with Out_Busy high for 4 cycles: four DRAIN cycles, then DONE.
        start_run(3, 1, 8, 2, 1);
        repeat (4) step();
        finish = 1; out_busy = 1;
        step();
        chk("finish_rd_drop", 64'(last_rd), 64'(0));
        finish = 0;
        drain = 0; dc = -1;
        for (int i = 1; i <= 20; i++) begin
            out_busy = (i <= 3);
            step();
            if (last_done) begin dc = i; break; end
            if (last_busy) drain++;
        end
        chk("finish_done",  64'(dc > 0), 64'(1));
        chk("drain_cycles", 64'(drain),  64'(4));
        done_ack = 1; step(); done_ack = 0;
        chk("ack_to_idle", 64'(busy | done), 64'(0));

        // Reset mid-STRIDE.
        start_run(3, 1, 8, 2, 1);
        for (int i = 0; i < 30; i++) begin
            if (col_idx == CNT_W'(5)) break;
            step();
        end
        chk("pre_reset_col", 64'(col_idx), 64'(5));
        do_reset();
        repeat (2) step();

        // Randomized traffic with config churn and a reset in the middle.
        for (int i = 0; i < 5000; i++) begin
            start        = ($urandom_range(0, 99) < 15);
            stop         = ($urandom_range(0, 99) < 4);
            finish       = ($urandom_range(0, 999) < 4);
            in_valid     = ($urandom_range(0, 99) < 70);
            out_busy     = ($urandom_range(0, 99) < 50);
            done_ack     = ($urandom_range(0, 99) < 30);
            cfg_kernel   = CNT_W'($urandom_range(0, 6));
            cfg_stride   = CNT_W'($urandom_range(0, 3));
            cfg_row_len  = CNT_W'($urandom_range(0, 8));
            cfg_rows     = CNT_W'($urandom_range(0, 3));
            cfg_channels = CH_W'($urandom_range(0, 3));
            if (i == 2500) do_reset();
            else           step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/omdc_param_controller.md
OMDC_PARAM_CONTROLLER -- requirements
Module: omdc_param_controller

Interface
REQ-001 The block SHALL have parameter CNT_W, default 10, width of column/stride/row counters and config inputs.
REQ-002 The block SHALL have parameter CH_W, default 6, width of channel counter and Cfg_Channels.
REQ-003 The block SHALL have port OMDC_STATEMACHINE_Clk, input, 1, clock; all state changes on the rising edge.
REQ-004 The block SHALL have port OMDC_STATEMACHINE_Reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port Start, input, 1, which starts a run from IDLE or resumes from PAUSED.
REQ-006 The block SHALL have ports Stop, input, 1, pause request, and Finish, input, 1, abort/finish request.
REQ-007 The block SHALL have ports In_Valid, input, 1, FIFO has a pixel, and Out_Busy, input, 1, output routine still active.
REQ-008 The block SHALL have port Done_Ack, input, 1, acknowledges Done.
REQ-009 The block SHALL have config inputs Cfg_Kernel, Cfg_Stride, Cfg_Row_Len and Cfg_Rows (each CNT_W), and Cfg_Channels (CH_W).
REQ-010 The block SHALL have outputs Rd_En, Window_Valid, Row_Reset, Chan_Reset, Busy and Done, each 1 bit.
REQ-011 The block SHALL have outputs Col_Idx (CNT_W), Row_Idx (CNT_W) and Chan_Idx (CH_W), giving current pixel position, row and channel.

Function
REQ-012 States SHALL be IDLE, FILL, STRIDE, NEXT_ROW, NEXT_CH, PAUSED, DRAIN and DONE, in a 3-bit registered encoding.
REQ-013 In IDLE with Start=1, the block SHALL latch all Cfg_* inputs (value 0 treated as 1), clear all counters and go to FILL.
REQ-014 Rd_En SHALL be (state is FILL or STRIDE) AND !Stop AND !Finish, combinationally; a pixel is accepted when Rd_En AND In_Valid.
REQ-015 Each accepted pixel SHALL increment Col_Idx; the first accepted pixel is Col_Idx 0.
REQ-016 In FILL, the acceptance at Col_Idx = Kernel-1 SHALL emit a window, clear the stride count and go to STRIDE.
REQ-017 In STRIDE, each accepted pixel SHALL increment the stride count; when the count reaches Stride-1 the block SHALL emit a window and clear the count.
REQ-018 Window_Valid SHALL be a registered one-cycle pulse, asserted in the cycle after the window-producing acceptance.
REQ-019 Acceptance at Col_Idx = Row_Len-1 (FILL or STRIDE) SHALL end the row and go to NEXT_CH if Row_Idx = Rows-1, else NEXT_ROW.
REQ-020 If Kernel > Row_Len, rows SHALL end in FILL and no window is emitted.
REQ-021 NEXT_ROW SHALL last one cycle: Row_Reset=1, Row_Idx+1, Col_Idx=0, then FILL.
REQ-022 NEXT_CH SHALL last one cycle: Chan_Reset=1, Row_Idx=0, Col_Idx=0; it then goes to DRAIN if Chan_Idx = Channels-1, else increments Chan_Idx and goes to FILL.
REQ-023 In FILL or STRIDE, priority SHALL be Finish > Stop > acceptance: Finish goes to DRAIN, Stop goes to PAUSED, and no pixel is accepted in that cycle.
REQ-024 PAUSED SHALL hold all counters, remember the interrupted state (FILL or STRIDE) and return to it on Start; Finish in PAUSED SHALL go to DRAIN.
REQ-025 DRAIN SHALL go to DONE when Out_Busy=0, and remain in DRAIN otherwise.
REQ-026 DONE SHALL drive Done=1 and go to IDLE on Done_Ack.
REQ-027 Busy SHALL be 1 in every state except IDLE and DONE.
REQ-028 Counters SHALL not wrap: Chan_Idx saturates at Channels-1, Row_Idx saturates at Rows-1, and Col_Idx is cleared at row end.

Reset
REQ-029 Asserting OMDC_STATEMACHINE_Reset (including mid-run) SHALL force IDLE and clear all counters, latched config and the pause memory.
REQ-030 During reset, all outputs SHALL be 0.
REQ-031 On reset release, the block SHALL do nothing until Start.

Configuration
REQ-032 With OMDC_WINDOW_COUNT_EN defined, the block SHALL add output Window_Count (2*CNT_W+CH_W bits); it increments on each Window_Valid, clears on run start, and holds through DONE.
REQ-033 Without OMDC_WINDOW_COUNT_EN, the Window_Count port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 Kernel=3, Stride=1, Row_Len=5, Rows=2, Channels=1, In_Valid=1, Start at cycle 0 -> 6 Window_Valid pulses, 1 Row_Reset, 1 Chan_Reset, and Done=1 at cycle 14 (Out_Busy=0).
REQ-035 Kernel=3, Stride=2, Row_Len=7, Rows=1, Channels=3 -> windows at Col_Idx 2, 4 and 6 per channel, 9 total, Chan_Idx ends at 2.
REQ-036 Stop in STRIDE at Col_Idx=3, then Start after 5 cycles -> no acceptance while paused, resume in STRIDE at Col_Idx 4, same total window count.
REQ-037 Finish with Out_Busy=1 for 4 cycles -> Rd_En drops the same cycle, DRAIN for 4 cycles, then DONE; Done_Ack -> IDLE.
REQ-038 Kernel=6, Row_Len=4 -> zero windows, and Row_Reset per row as normal.
REQ-039 Reset pulse mid-STRIDE -> IDLE, all outputs 0, and Window_Count=0 with OMDC_WINDOW_COUNT_EN defined.
